// File: rtl/alarm_unit_if.sv
// alarm_unit_if: time-of-day inputs, alarm programming/control and alarm status bundle
interface alarm_unit_if;
  logic       ena;
  logic [7:0] hh;
  logic [7:0] mm;
  logic [7:0] ss;
  logic       pm;
  logic       arm_en;
  logic       set_valid;
  logic [7:0] set_hh;
  logic [7:0] set_mm;
  logic       set_pm;
  logic       snooze;
  logic       dismiss;
  logic       buzz;
  logic       snoozing;
  logic       armed;
  logic       set_err;
  logic [7:0] al_hh;
  logic [7:0] al_mm;
  logic       al_pm;
  modport master (
    output ena, hh, mm, ss, pm, arm_en, set_valid, set_hh, set_mm, set_pm, snooze, dismiss,
    input  buzz, snoozing, armed, set_err, al_hh, al_mm, al_pm
  );
  modport slave (
    input  ena, hh, mm, ss, pm, arm_en, set_valid, set_hh, set_mm, set_pm, snooze, dismiss,
    output buzz, snoozing, armed, set_err, al_hh, al_mm, al_pm
  );
endinterface

// File: rtl/alarm_unit.sv
// alarm_unit: 12h BCD alarm with timeout, dismiss and hold-off; snooze built only when ALARM_SNOOZE_EN is defined
module alarm_unit #(
  parameter int RING_SECS   = 60,
  parameter int SNOOZE_SECS = 300
) (
  input logic        clk,
  input logic        reset,
  alarm_unit_if.slave bus
);
`ifdef ALARM_SNOOZE_EN
  typedef enum logic [1:0] {IDLE, ARMED, RINGING, SNOOZE} state_t;
  localparam logic [15:0] SNZ_LAST = 16'(SNOOZE_SECS - 1);
`else
  typedef enum logic [1:0] {IDLE, ARMED, RINGING} state_t;
`endif
  localparam logic [15:0] RING_LAST = 16'(RING_SECS - 1);
  state_t      st, st_n;
  logic [15:0] cnt, cnt_n, cnt_inc;
  logic        hold, hold_n, match, ok, rej, live;
  assign ok = ((bus.set_hh[7:4] == 4'd0 && bus.set_hh[3:0] != 4'd0 && bus.set_hh[3:0] <= 4'd9) ||
               (bus.set_hh[7:4] == 4'd1 && bus.set_hh[3:0] <= 4'd2)) &&
              bus.set_mm[7:4] <= 4'd5 && bus.set_mm[3:0] <= 4'd9;
  assign rej = bus.set_valid & ~ok;
  assign match = {bus.hh, bus.mm, bus.ss, bus.pm} == {bus.al_hh, bus.al_mm, 8'h00, bus.al_pm};
  assign cnt_inc = cnt == 16'hFFFF ? cnt : cnt + 16'd1;
`ifdef ALARM_SNOOZE_EN
  assign live = st == RINGING || st == SNOOZE;
`else
  logic snooze_unused;
  assign snooze_unused = bus.snooze;
  assign live = st == RINGING;
  assign bus.snoozing = 1'b0;
`endif
  always_comb begin
    st_n = st;
    cnt_n = cnt;
    // a rejected load freezes everything, including the hold-off flag
    hold_n = rej ? hold : hold & match;
    if (!bus.arm_en) begin
      st_n = IDLE;
      cnt_n = '0;
    end else if (bus.set_valid) begin
      if (ok && live) begin
        st_n = ARMED;
        hold_n = 1'b0;
        cnt_n = '0;
      end
    end else if (bus.dismiss && live) begin
      st_n = ARMED;
      hold_n = 1'b1;
      cnt_n = '0;
`ifdef ALARM_SNOOZE_EN
    end else if (bus.snooze && st == RINGING) begin
      st_n = SNOOZE;
      cnt_n = '0;
    end else if (st == SNOOZE) begin
      if (bus.ena) begin
        st_n = cnt == SNZ_LAST ? RINGING : SNOOZE;
        cnt_n = cnt == SNZ_LAST ? '0 : cnt_inc;
      end
`endif
    end else if (st == RINGING) begin
      if (bus.ena) begin
        st_n = cnt == RING_LAST ? ARMED : RINGING;
        hold_n = cnt == RING_LAST ? 1'b1 : hold_n;
        cnt_n = cnt == RING_LAST ? '0 : cnt_inc;
      end
    end else if (st == IDLE) begin
      st_n = ARMED;
    end else if (match && !hold) begin
      st_n = RINGING;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      st <= IDLE;
      cnt <= '0;
      hold <= 1'b0;
      bus.buzz <= 1'b0;
      bus.armed <= 1'b0;
      bus.set_err <= 1'b0;
      bus.al_hh <= 8'h12;
      bus.al_mm <= 8'h00;
      bus.al_pm <= 1'b0;
`ifdef ALARM_SNOOZE_EN
      bus.snoozing <= 1'b0;
`endif
    end else begin
      st <= st_n;
      cnt <= cnt_n;
      hold <= hold_n;
      bus.buzz <= st_n == RINGING;
      bus.armed <= st_n != IDLE;
      bus.set_err <= rej;
      bus.al_hh <= bus.set_valid && ok ? bus.set_hh : bus.al_hh;
      bus.al_mm <= bus.set_valid && ok ? bus.set_mm : bus.al_mm;
      bus.al_pm <= bus.set_valid && ok ? bus.set_pm : bus.al_pm;
`ifdef ALARM_SNOOZE_EN
      bus.snoozing <= st_n == SNOOZE;
`endif
    end
  end
endmodule

// File: tb/tb_alarm_unit.sv
// tb_alarm_unit: directed scenarios plus randomized traffic checked against a countdown-style behavioural model
module tb_alarm_unit;
  localparam int RS = 3;
  localparam int SS = 2;
`ifdef ALARM_SNOOZE_EN
  localparam bit SNZ = 1'b1;
`else
  localparam bit SNZ = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset = 1'b1;
  alarm_unit_if bus();
  alarm_unit #(.RING_SECS(RS), .SNOOZE_SECS(SS)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;
  bit m_ring, m_snz, m_arm, m_err, m_hold, m_pm;
  logic [7:0] m_hh, m_mm;
  int left;

  task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit hour_ok(logic [7:0] b);
    int v = int'(b[7:4]) * 10 + int'(b[3:0]);
    return b[7:4] <= 9 && b[3:0] <= 9 && v >= 1 && v <= 12;
  endfunction

  function automatic bit min_ok(logic [7:0] b);
    return b[7:4] <= 5 && b[3:0] <= 9;
  endfunction

  // Model: alarm status booleans plus a "ticks remaining" countdown for ringing/snoozing.
  task automatic model_step();
    bit match, ok, rejected;
    if (reset) begin
      {m_ring, m_snz, m_arm, m_err, m_hold, m_pm} = '0;
      m_hh = 8'h12;
      m_mm = 8'h00;
      left = 0;
      return;
    end
    match = bus.hh == m_hh && bus.mm == m_mm && bus.ss == 8'h00 && bus.pm == m_pm;
    ok = hour_ok(bus.set_hh) && min_ok(bus.set_mm);
    rejected = bus.set_valid && !ok;
    m_err = rejected;
    if (bus.set_valid && ok) begin
      m_hh = bus.set_hh;
      m_mm = bus.set_mm;
      m_pm = bus.set_pm;
    end
    if (!rejected && !match) m_hold = 0;
    if (!bus.arm_en) begin
      {m_ring, m_snz, m_arm} = '0;
      return;
    end
    if (rejected) return;
    if (bus.set_valid) begin
      if (m_ring || m_snz) begin
        {m_ring, m_snz} = '0;
        m_hold = 0;
      end
      return;
    end
    if (bus.dismiss && (m_ring || m_snz)) begin
      {m_ring, m_snz} = '0;
      m_hold = 1;
      return;
    end
    if (SNZ && bus.snooze && m_ring) begin
      m_ring = 0;
      m_snz = 1;
      left = SS;
      return;
    end
    if (m_ring) begin
      if (bus.ena) begin
        if (left == 1) begin
          m_ring = 0;
          m_hold = 1;
        end else left--;
      end
      return;
    end
    if (m_snz) begin
      if (bus.ena) begin
        if (left == 1) begin
          m_snz = 0;
          m_ring = 1;
          left = RS;
        end else left--;
      end
      return;
    end
    if (!m_arm) m_arm = 1;
    else if (match && !m_hold) begin
      m_ring = 1;
      left = RS;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("buzz", bus.buzz, m_ring);
      chk("snoozing", bus.snoozing, m_snz);
      chk("armed", bus.armed, m_arm);
      chk("set_err", bus.set_err, m_err);
      chk("al_hh", bus.al_hh, m_hh);
      chk("al_mm", bus.al_mm, m_mm);
      chk("al_pm", bus.al_pm, m_pm);
    end
  end

  initial begin
    {bus.ena, bus.pm, bus.arm_en, bus.set_valid, bus.set_pm, bus.snooze, bus.dismiss} = '0;
    {bus.hh, bus.mm, bus.ss, bus.set_hh, bus.set_mm} = '0;
    cyc();
    chk_on = 1'b1;
    cyc();
    chk("rst_al_hh", bus.al_hh, 8'h12);
    chk("rst_al_mm", bus.al_mm, 8'h00);
    chk("rst_al_pm", bus.al_pm, 0);
    chk("rst_buzz", bus.buzz, 0);
    chk("rst_armed", bus.armed, 0);
    reset = 0;
    // load 06:30 PM and ring at 06:30:00 PM, timeout after RS ticks
    bus.arm_en = 1; bus.set_valid = 1; bus.set_hh = 8'h06; bus.set_mm = 8'h30; bus.set_pm = 1;
    bus.hh = 8'h06; bus.mm = 8'h29; bus.ss = 8'h59; bus.pm = 1;
    cyc();
    bus.set_valid = 0;
    chk("ld_hh", bus.al_hh, 8'h06);
    chk("ld_mm", bus.al_mm, 8'h30);
    chk("ld_pm", bus.al_pm, 1);
    cyc();
    chk("armed_on", bus.armed, 1);
    bus.mm = 8'h30; bus.ss = 8'h00;
    cyc();
    chk("ring_on", bus.buzz, 1);
    chk("mdl_ring_on", m_ring, 1);
    bus.ena = 1; cyc(); bus.ena = 0; cyc();
    bus.ena = 1; cyc(); bus.ena = 0;
    chk("ring_2tick", bus.buzz, 1);
    cyc();
    bus.ena = 1; cyc(); bus.ena = 0;
    chk("timeout", bus.buzz, 0);
    chk("timeout_armed", bus.armed, 1);
    cyc(); cyc();
    chk("holdoff", bus.buzz, 0);
    chk("mdl_holdoff", m_ring, 0);
    // rejected loads
    bus.set_valid = 1; bus.set_hh = 8'h13; bus.set_mm = 8'h15;
    cyc();
    bus.set_valid = 0;
    chk("rej_hh_err", bus.set_err, 1);
    chk("rej_hh_keep", bus.al_hh, 8'h06);
    cyc();
    chk("err_pulse", bus.set_err, 0);
    bus.set_valid = 1; bus.set_hh = 8'h06; bus.set_mm = 8'h5A;
    cyc();
    bus.set_valid = 0;
    chk("rej_mm_err", bus.set_err, 1);
    chk("rej_mm_keep", bus.al_mm, 8'h30);
    // snooze (ignored when not built), then dismiss+snooze together
    bus.ss = 8'h01; cyc(); bus.ss = 8'h00; cyc();
    chk("ring_again", bus.buzz, 1);
    bus.snooze = 1; cyc(); bus.snooze = 0;
    chk("snz_buzz", bus.buzz, !SNZ);
    chk("snz_flag", bus.snoozing, SNZ);
    bus.ena = 1; cyc(); bus.ena = 0; cyc();
    chk("snz_1tick", bus.buzz, !SNZ);
    bus.ena = 1; cyc(); bus.ena = 0;
    chk("snz_resume", bus.buzz, 1);
    chk("snz_resume_flag", bus.snoozing, 0);
    bus.dismiss = 1; bus.snooze = 1; cyc(); bus.dismiss = 0; bus.snooze = 0;
    chk("dis_buzz", bus.buzz, 0);
    chk("dis_snz", bus.snoozing, 0);
    chk("dis_armed", bus.armed, 1);
    // arm_en drop while ringing, then re-arm during the same matching second
    bus.ss = 8'h01; cyc(); bus.ss = 8'h00; cyc();
    chk("ring_3", bus.buzz, 1);
    bus.arm_en = 0; cyc();
    chk("off_buzz", bus.buzz, 0);
    chk("off_armed", bus.armed, 0);
    chk("off_snz", bus.snoozing, 0);
    bus.arm_en = 1; cyc();
    chk("rearm", bus.armed, 1);
    cyc();
    chk("rearm_ring", bus.buzz, 1);
    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      int r, v;
      reset = $urandom_range(0, 499) == 0;
      bus.arm_en = $urandom_range(0, 39) != 0;
      bus.ena = $urandom_range(0, 3) == 0;
      bus.snooze = $urandom_range(0, 24) == 0;
      bus.dismiss = $urandom_range(0, 29) == 0;
      bus.set_valid = $urandom_range(0, 29) == 0;
      v = $urandom_range(0, 14);
      bus.set_hh = $urandom_range(0, 7) == 0 ? 8'($urandom) : 8'((v / 10) * 16 + v % 10);
      v = $urandom_range(0, 61);
      bus.set_mm = $urandom_range(0, 7) == 0 ? 8'($urandom) : 8'((v / 10) * 16 + v % 10);
      bus.set_pm = 1'($urandom);
      if ($urandom_range(0, 3) != 0) begin
        bus.hh = m_hh; bus.mm = m_mm; bus.pm = m_pm;
      end else begin
        v = $urandom_range(1, 12);
        bus.hh = 8'((v / 10) * 16 + v % 10);
        v = $urandom_range(0, 59);
        bus.mm = 8'((v / 10) * 16 + v % 10);
        bus.pm = 1'($urandom);
      end
      r = $urandom_range(0, 3);
      bus.ss = r < 2 ? 8'h00 : r == 2 ? 8'h01 : 8'h37;
      cyc();
    end
    chk_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/alarm_unit.md
# alarm_unit

Alarm stage that sits directly downstream of the 12-hour BCD time-of-day counter. It consumes the counter's `hh`/`mm`/`ss`/`pm` outputs and its one-second `ena` tick, and holds a programmable alarm time. It raises `buzz` when the running time reaches the alarm time, with auto-timeout, dismiss and optional snooze. All outputs are registered and driven from a single state machine.

## Interface

Parameters:
- `RING_SECS`, default 60: number of `ena` ticks RINGING lasts before it times out; legal range 1..65535.
- `SNOOZE_SECS`, default 300: number of `ena` ticks SNOOZE lasts; legal range 1..65535.

Ports:
- `clk` input 1: single clock. Rising edge only.
- `reset` input 1: synchronous, active-high.
- `ena` input 1: one-second tick, the same signal that enables the time counter; one cycle wide.
- `hh` input 8: current hour, BCD, 01..12.
- `mm` input 8: current minute, BCD, 00..59.
- `ss` input 8: current second, BCD, 00..59.
- `pm` input 1: current meridiem; 1 = PM.
- `arm_en` input 1: level. When low, the alarm is disabled.
- `set_valid` input 1: one-cycle load strobe for the alarm time.
- `set_hh` input 8: alarm hour, BCD.
- `set_mm` input 8: alarm minute, BCD.
- `set_pm` input 1: alarm meridiem.
- `snooze` input 1: request snooze; level sampled each cycle.
- `dismiss` input 1: stop the alarm; level sampled each cycle.
- `buzz` output 1: high while in RINGING.
- `snoozing` output 1: high while in SNOOZE.
- `armed` output 1: high in ARMED, RINGING or SNOOZE.
- `set_err` output 1: one-cycle pulse when a load is rejected.
- `al_hh` output 8: stored alarm hour.
- `al_mm` output 8: stored alarm minute.
- `al_pm` output 1: stored alarm meridiem.

## Operation

States: IDLE, ARMED, RINGING, SNOOZE.

- Reset values:
  - State is IDLE.
  - `buzz`, `snoozing`, `armed`, `set_err` are 0.
  - `al_hh`=8'h12, `al_mm`=8'h00, `al_pm`=0 (12:00 AM).
  - Tick counter is 0.
  - Hold-off flag is 0.
- `match` condition: all of the following hold:
  - `{hh,mm,ss}=={al_hh,al_mm,8'h00}`
  - `pm==al_pm`
- Load rules:
  - `set_valid` is accepted only when `set_hh` is a BCD value in 01..12 and `set_mm` is a BCD value in 00..59; both digits must be ≤9.
  - An accepted load writes `al_*`.
  - If the state is RINGING or SNOOZE, an accepted load moves it to ARMED with hold-off cleared.
  - A rejected load leaves all state unchanged and pulses `set_err`.
- Transitions, with priority from high to low within a cycle:
  1. `reset`.
  2. `arm_en`=0: any state goes to IDLE and the counter clears.
  3. `set_valid`.
  4. `dismiss`: RINGING or SNOOZE goes to ARMED, hold-off is set, counter clears.
  5. `snooze`: RINGING goes to SNOOZE, counter clears.
  6. Timers:
     - RINGING: counter increments on `ena`. When the counter reaches RING_SECS-1 and `ena` is high, go to ARMED, set hold-off, clear the counter.
     - SNOOZE: counter increments on `ena`. When the counter reaches SNOOZE_SECS-1 and `ena` is high, go to RINGING and clear the counter.
  7. Arming and triggering:
     - IDLE with `arm_en`=1 goes to ARMED.
     - ARMED with `match` and hold-off=0 goes to RINGING.
- Hold-off flag:
  - Clears on the first cycle where `match` is 0.
  - Prevents a retrigger within the same matching second after dismiss or timeout.
- In SNOOZE, `match` is ignored; snooze always resumes RINGING, not ARMED.
- The counter is 16 bits and saturates; it never wraps.

## Timing

- `set_valid` in cycle N: `al_*` and `set_err` are updated or asserted in cycle N+1.
- `match` true in cycle N: `buzz`=1 from cycle N+1.
- `dismiss` or `snooze` in cycle N: `buzz`=0 from cycle N+1. For `snooze`, `snoozing`=1 from N+1.
- Timeout: `buzz` falls in the cycle after the RING_SECS-th `ena` pulse counted in RINGING. The match cycle itself is not counted.
- `arm_en` falling in cycle N: `armed`, `buzz` and `snoozing` are all 0 in cycle N+1.
- `reset` mid-ring: all outputs return to their reset values on the next edge. The stored alarm time is lost.
- `dismiss` and `snooze` asserted together: `dismiss` wins.

## Configuration

- `ALARM_SNOOZE_EN` defined:
  - SNOOZE state is present.
  - `snooze` input is honoured.
  - SNOOZE_SECS is used.
- `ALARM_SNOOZE_EN` undefined:
  - SNOOZE state is not built.
  - `snooze` input is ignored.
  - `snoozing` is tied to 0.
  - The only exits from RINGING are `dismiss`, timeout, load, `arm_en` low and `reset`.

## Test plan

- Reset, then read outputs -> `al_hh`=12, `al_mm`=00, `al_pm`=0, `buzz`=0, `armed`=0.
- Load 06:30 PM, hold `arm_en`=1, drive the time to 06:30:00 PM -> `buzz`=1 on the next cycle. With RING_SECS=3, `buzz` clears after the 3rd `ena` pulse and the alarm does not retrigger during the rest of second 00.
- Load `set_hh`=8'h13, then load `set_mm`=8'h5A -> `set_err` pulses once per load and `al_*` is unchanged.
- While ringing, pulse `snooze` with SNOOZE_SECS=2 -> `buzz`=0 and `snoozing`=1. After 2 `ena` pulses, `buzz`=1 again. Then `dismiss` and `snooze` asserted in the same cycle -> ARMED with `buzz`=0 and `snoozing`=0.
- While ringing, drop `arm_en` -> all outputs 0 next cycle. Raise `arm_en` while `match` is still true -> rings again, since hold-off is not set on this path.
- Build without `ALARM_SNOOZE_EN`, pulse `snooze` while ringing -> `buzz` stays 1 and `snoozing` stays 0.
